mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 32, bus address width; DW, 32, bus data width; TIMEOUT, 16, cycles to wait for ack before aborting.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 Pipeline ports: req_i in 1 MEM stage holds a load/store; we_i in 1 store; addr_i in AW byte address; sel_i in DW/8 byte lanes; wdata_i in DW store data.
REQ-004 Pipeline control ports: flush_i in 1 exception flush; stall_i in 1 MEM stage held by ctrl; stallreq_o out 1 stall request to ctrl.
REQ-005 Result ports: rdata_o out DW load data; err_o out 1 bus error/timeout pulse.
REQ-006 Bus ports: wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_adr_o out AW; wb_sel_o out DW/8; wb_dat_o out DW; wb_dat_i in DW; wb_ack_i in 1.

Function
REQ-007 States SHALL be IDLE, BUSY, DONE, DRAIN.
REQ-008 IDLE with req_i=1 and flush_i=0: stallreq_o=1 same cycle; addr/we/sel/wdata latched; next state BUSY.
REQ-009 BUSY: wb_cyc_o=wb_stb_o=1, bus outputs driven from latched request only; stallreq_o=1.
REQ-010 BUSY with wb_ack_i=1: rdata_o <= wb_dat_i on loads, held unchanged on stores; cyc/stb drop next cycle; next state DONE.
REQ-011 DONE: stallreq_o=0; rdata_o stable; no new bus cycle issued; stays DONE while stall_i=1, goes IDLE when stall_i=0.
REQ-012 Minimum latency: req at cycle 0, ack at cycle 1 -> stallreq_o low at cycle 2; two stall cycles total.
REQ-013 flush_i=1 in BUSY without ack: go DRAIN; stallreq_o=0; bus cycle continues until ack; ack data discarded; then IDLE.
REQ-014 flush_i=1 in BUSY same cycle as ack: go IDLE, rdata_o unchanged, err_o=0.
REQ-015 flush_i=1 in IDLE or DONE: next state IDLE, no bus cycle.
REQ-016 DRAIN with req_i=1: stallreq_o=1; request not latched until IDLE.
REQ-017 wb_cyc_o and wb_stb_o SHALL be registered; never high outside BUSY/DRAIN.
REQ-018 err_o SHALL be 0 except as in REQ-021.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE; cyc/stb/we=0; adr/sel/dat_o/rdata_o=0; stallreq_o=0; err_o=0; timeout counter 0.
REQ-020 Reset mid-BUSY SHALL drop cyc/stb on the next edge; the pending ack is ignored.

Configuration
REQ-021 With BUS_TIMEOUT_EN defined: a counter clears on BUSY/DRAIN entry and increments each cycle without ack. On reaching TIMEOUT in BUSY: drop cyc/stb, rdata_o <= 0, err_o=1 for one cycle in DONE. On reaching TIMEOUT in DRAIN: IDLE, no err_o.
REQ-022 Without BUS_TIMEOUT_EN: no counter; err_o tied 0; BUSY/DRAIN wait indefinitely for ack.

Structure
REQ-023 Shared package mem_bus_pkg SHALL hold the state enum, ZeroWord, the default TIMEOUT constant, and lane-select constants.
REQ-024 The timeout counter SHALL be sub-module bus_timer, instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-025 Load addr 0x100, ack 1 cycle later with data 0xDEADBEEF -> 2 stall cycles; rdata_o=0xDEADBEEF in DONE; wb_we_o=0.
REQ-026 Store addr 0x200, sel 0xF, wdata 0x12345678, ack after 3 wait cycles -> wb_dat_o=0x12345678, wb_we_o=1; stallreq_o high 4 cycles then low.
REQ-027 flush_i during BUSY, ack 2 cycles later -> stallreq_o drops the cycle after flush; cyc held until ack; rdata_o unchanged.
REQ-028 Ack arrives while stall_i=1 for 3 cycles -> held in DONE 3 cycles; no second bus cycle; rdata_o stable; then IDLE.
REQ-029 BUS_TIMEOUT_EN, TIMEOUT=4, no ack -> cyc drops after 4 BUSY cycles; err_o pulses once; rdata_o=0.
REQ-030 rst asserted in BUSY with ack the same cycle -> all outputs 0 next cycle; IDLE; ack data discarded.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage bus controller.
// Optional feature macro used by this slice: BUS_TIMEOUT_EN (bus ack timeout).
package mem_bus_pkg;

    // Controller states:
    //   ST_IDLE  | no access outstanding, ready to accept the MEM-stage request
    //   ST_BUSY  | bus cycle in flight for the latched request, pipeline stalled
    //   ST_DONE  | access finished, result held while the pipeline is frozen
    //   ST_DRAIN | request flushed, bus cycle still waiting for its ack
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam int          DefaultTimeout = 16;

    // Byte-lane select patterns for a 32-bit data bus.
    localparam logic [3:0] SelByte0 = 4'b0001;
    localparam logic [3:0] SelByte1 = 4'b0010;
    localparam logic [3:0] SelByte2 = 4'b0100;
    localparam logic [3:0] SelByte3 = 4'b1000;
    localparam logic [3:0] SelHalf0 = 4'b0011;
    localparam logic [3:0] SelHalf1 = 4'b1100;
    localparam logic [3:0] SelWord  = 4'b1111;

    // True while a bus cycle is owned by the controller.
    function automatic logic bus_active(input state_e s);
        return (s == ST_BUSY) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Ack timeout counter for mem_bus_ctrl.
// Only elaborated when BUS_TIMEOUT_EN is defined; the default build carries no timer.
`ifdef BUS_TIMEOUT_EN
module bus_timer
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int          CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // The count equals the number of ack-less cycles already spent, so the
    // cycle holding Last is the TIMEOUT-th one and expires if still no ack.
    assign expired_o = run_i && !ack_i && (cnt_q == Last);

    // Clear outside the counted phase, otherwise count each cycle without ack.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && !ack_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store to single-master bus controller.
// Optional feature: define BUS_TIMEOUT_EN to abort bus cycles that see no ack
// within TIMEOUT cycles (sub-module bus_timer).
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DefaultTimeout
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            flush_i,
    input  logic            stall_i,
    output logic            stallreq_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i
);

    localparam int SW = DW / 8;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            stall_req;
    logic            timeout_hit;

`ifdef BUS_TIMEOUT_EN
    logic timer_clr;

    // Hold the counter at zero except while BUSY continues or DRAIN runs, so
    // it starts from zero on entry to either state.
    assign timer_clr = !((state_q == ST_BUSY && !flush_i) || state_q == ST_DRAIN);

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .run_i     (bus_active(state_q)),
        .ack_i     (wb_ack_i),
        .expired_o (timeout_hit)
    );
`else
    // No timer: bus cycles wait for ack forever. The comparison is constant
    // false and only keeps TIMEOUT referenced in this build.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // Next-state, request latch, read-data capture and stall request.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        stall_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    stall_req = 1'b1;
                    we_d      = we_i;
                    adr_d     = addr_i;
                    sel_d     = sel_i;
                    dat_d     = wdata_i;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                stall_req = 1'b1;
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (flush_i) begin
                        // Killed instruction: result is dropped.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        if (!we_q) begin
                            rdata_d = wb_dat_i;
                        end
                    end
                end else if (timeout_hit) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = DW'(ZeroWord);
                        err_d   = 1'b1;
                    end
                end else if (flush_i) begin
                    // Bus cycle cannot be withdrawn; release the pipeline
                    // and swallow the ack when it comes.
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                if (flush_i || !stall_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // A new request must wait until the old cycle has drained.
                stall_req = req_i;
                if (wb_ack_i || timeout_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stall request is combinational so the pipeline freezes in the request
    // cycle; it is held low while reset is applied.
    assign stallreq_o = stall_req && !rst;
    assign rdata_o    = rdata_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_sel_o   = sel_q;
    assign wb_dat_o   = dat_q;

`ifdef BUS_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios followed by a
// randomized mix, checked against a transaction-level expectation of the
// stall window, bus-cycle window and returned load data.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i, we_i, flush_i, stall_i;
    logic [31:0] addr_i, wdata_i, wb_dat_i;
    logic [3:0]  sel_i;
    logic        wb_ack_i;
    logic        stallreq_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_bus_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .sel_i      (sel_i),
        .wdata_i    (wdata_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .stallreq_o (stallreq_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Request inputs change after the request cycle; the bus must not follow.
    task automatic scramble();
        we_i    = 1'($urandom_range(0, 1));
        addr_i  = $urandom;
        sel_i   = 4'($urandom);
        wdata_i = $urandom;
    endtask

    task automatic present(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = adr;
        sel_i   = sel;
        wdata_i = wd;
        flush_i = 1'b0;
        stall_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] wd);
        chk({tag, "_adr"}, wb_adr_o, adr);
        chk({tag, "_we"},  wb_we_o,  we);
        chk({tag, "_sel"}, wb_sel_o, sel);
        if (we) chk({tag, "_dat"}, wb_dat_o, wd);
    endtask

    // Complete access: request in cycle 0, ack in cycle ack_at, so the stall
    // request is high for ack_at+1 cycles and the bus cycle for ack_at cycles.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] ack_d,
                       input int hold);
        present(we, adr, sel, wd);
        for (int k = 0; k <= ack_at; k++) begin
            if (k > 0) scramble();
            wb_ack_i = (k == ack_at);
            wb_dat_i = (k == ack_at) ? ack_d : $urandom;
            @(negedge clk);
            chk("txn_stallreq", stallreq_o, 1'b1);
            chk("txn_cyc", wb_cyc_o, (k > 0));
            chk("txn_stb", wb_stb_o, (k > 0));
            chk("txn_rdata_old", rdata_o, exp_rdata);
            chk("txn_err", err_o, 1'b0);
            if (k > 0) chk_bus("txn", we, adr, sel, wd);
            tick();
        end
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        if (!we) exp_rdata = ack_d;
        for (int h = 0; h <= hold; h++) begin
            stall_i = (h < hold);
            @(negedge clk);
            chk("done_stallreq", stallreq_o, 1'b0);
            chk("done_cyc", wb_cyc_o, 1'b0);
            chk("done_rdata", rdata_o, exp_rdata);
            chk("done_err", err_o, 1'b0);
            tick();
        end
        stall_i = 1'b0;
        req_i   = 1'b0;
        @(negedge clk);
        chk("post_cyc", wb_cyc_o, 1'b0);
        chk("post_stallreq", stallreq_o, 1'b0);
        tick();
    endtask

    // Flush in BUSY cycle f with no ack, then ack in the d-th drain cycle.
    task automatic flush_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] wd, input int f, input int d,
                             input logic rand_req);
        present(we, adr, sel, wd);
        @(negedge clk);
        chk("fl_req_stallreq", stallreq_o, 1'b1);
        tick();
        for (int k = 1; k <= f; k++) begin
            scramble();
            flush_i = (k == f);
            @(negedge clk);
            chk("fl_busy_stallreq", stallreq_o, 1'b1);
            chk("fl_busy_cyc", wb_cyc_o, 1'b1);
            tick();
        end
        flush_i = 1'b0;
        for (int j = 1; j <= d; j++) begin
            req_i    = rand_req ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_ack_i = (j == d);
            wb_dat_i = $urandom;
            @(negedge clk);
            chk("drain_stallreq", stallreq_o, req_i);
            chk("drain_cyc", wb_cyc_o, 1'b1);
            chk("drain_stb", wb_stb_o, 1'b1);
            chk("drain_adr", wb_adr_o, adr);
            chk("drain_rdata", rdata_o, exp_rdata);
            tick();
        end
        wb_ack_i = 1'b0;
        req_i    = 1'b0;
        @(negedge clk);
        chk("drain_end_cyc", wb_cyc_o, 1'b0);
        chk("drain_end_stallreq", stallreq_o, 1'b0);
        chk("drain_end_rdata", rdata_o, exp_rdata);
        chk("drain_end_err", err_o, 1'b0);
        tick();
    endtask

    // Flush arriving in the same cycle as the ack: result dropped.
    task automatic flush_ack_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] wd, input int ack_at);
        present(we, adr, sel, wd);
        tick();
        for (int k = 1; k <= ack_at; k++) begin
            scramble();
            wb_ack_i = (k == ack_at);
            flush_i  = (k == ack_at);
            wb_dat_i = $urandom;
            @(negedge clk);
            chk("fa_cyc", wb_cyc_o, 1'b1);
            chk("fa_stallreq", stallreq_o, 1'b1);
            tick();
        end
        wb_ack_i = 1'b0;
        flush_i  = 1'b0;
        req_i    = 1'b0;
        @(negedge clk);
        chk("fa_cyc_after", wb_cyc_o, 1'b0);
        chk("fa_rdata", rdata_o, exp_rdata);
        chk("fa_err", err_o, 1'b0);
        chk("fa_stallreq_after", stallreq_o, 1'b0);
        tick();
    endtask

    // Flush while idle with a request pending: nothing starts.
    task automatic idle_flush();
        present(1'($urandom_range(0, 1)), $urandom, 4'hF, $urandom);
        flush_i = 1'b1;
        @(negedge clk);
        chk("if_stallreq", stallreq_o, 1'b0);
        tick();
        req_i   = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("if_cyc", wb_cyc_o, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; wdata_i = '0;
        flush_i = 1'b0; stall_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_stallreq", stallreq_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst = 1'b0;
        tick();

        // Load at 0x100, ack one cycle later.
        txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1, 32'hDEAD_BEEF, 0);
        // Store at 0x200, ack three cycles after the request.
        txn(1'b1, 32'h0000_0200, 4'hF, 32'h1234_5678, 3, 32'hCAFE_F00D, 0);
        // Flush in the first BUSY cycle, ack two cycles later.
        flush_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 1, 2, 1'b0);
        // Pipeline held three cycles after the ack.
        txn(1'b0, 32'h0000_0400, 4'h3, 32'h0, 2, 32'h0BAD_F00D, 3);
        flush_ack_txn(1'b0, 32'h0000_0500, 4'hF, 32'h0, 2);
        idle_flush();

        // Reset in BUSY in the same cycle as the ack.
        present(1'b0, 32'h0000_0600, 4'hF, 32'h0);
        tick();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_AAAA;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        req_i    = 1'b0;
        wb_ack_i = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        chk("rb_cyc", wb_cyc_o, 1'b0);
        chk("rb_stb", wb_stb_o, 1'b0);
        chk("rb_we", wb_we_o, 1'b0);
        chk("rb_adr", wb_adr_o, 32'h0);
        chk("rb_sel", wb_sel_o, 4'h0);
        chk("rb_dat", wb_dat_o, 32'h0);
        chk("rb_rdata", rdata_o, 32'h0);
        chk("rb_stallreq", stallreq_o, 1'b0);
        chk("rb_err", err_o, 1'b0);
        tick();
        txn(1'b0, 32'h0000_0700, 4'hF, 32'h0, 1, 32'h7777_0001, 0);

`ifdef BUS_TIMEOUT_EN
        // No ack in BUSY: four bus cycles, then an error pulse with zero data.
        present(1'b0, 32'h0000_0800, 4'hF, 32'h0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("to_cyc", wb_cyc_o, 1'b1);
            chk("to_err_busy", err_o, 1'b0);
            tick();
        end
        stall_i = 1'b1;
        exp_rdata = 32'h0;
        @(negedge clk);
        chk("to_cyc_drop", wb_cyc_o, 1'b0);
        chk("to_err_pulse", err_o, 1'b1);
        chk("to_rdata", rdata_o, 32'h0);
        chk("to_stallreq", stallreq_o, 1'b0);
        tick();
        stall_i = 1'b0;
        @(negedge clk);
        chk("to_err_once", err_o, 1'b0);
        tick();
        req_i = 1'b0;
        @(negedge clk);
        chk("to_idle_cyc", wb_cyc_o, 1'b0);
        tick();

        // No ack in DRAIN: four drain cycles, then idle without error.
        present(1'b0, 32'h0000_0900, 4'hF, 32'h0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        req_i   = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("tod_cyc", wb_cyc_o, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("tod_cyc_drop", wb_cyc_o, 1'b0);
        chk("tod_err", err_o, 1'b0);
        tick();
`endif

        for (int it = 0; it < 60; it++) begin
            logic        r_we;
            logic [31:0] r_adr, r_wd, r_ack;
            logic [3:0]  r_sel;
            int          kind;
            kind  = int'($urandom_range(0, 3));
            r_we  = 1'($urandom_range(0, 1));
            r_adr = $urandom;
            r_sel = 4'($urandom_range(1, 15));
            r_wd  = $urandom;
            r_ack = $urandom;
            case (kind)
                0: txn(r_we, r_adr, r_sel, r_wd, int'($urandom_range(1, 4)), r_ack,
                       int'($urandom_range(0, 3)));
                1: flush_txn(r_we, r_adr, r_sel, r_wd, int'($urandom_range(1, 3)),
                             int'($urandom_range(1, 4)), 1'b1);
                2: flush_ack_txn(r_we, r_adr, r_sel, r_wd, int'($urandom_range(1, 4)));
                default: idle_flush();
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
